// File: rtl/display_timing_gen_if.sv
// Raster timing bundle: advance enable in, coordinates, flags and frame count out.
// The generator drives through master; the pixel painter reads through slave.
interface display_timing_gen_if #(
    parameter int CORDW  = 10,
    parameter int FRAMEW = 16
);
    logic              en;
    logic [CORDW-1:0]  sx;
    logic [CORDW-1:0]  sy;
    logic              de;
    logic              hsync;
    logic              vsync;
    logic              line;
    logic              frame;
    logic [FRAMEW-1:0] frame_cnt;

    modport master (
        input  en,
        output sx, sy, de, hsync, vsync, line, frame, frame_cnt
    );

    modport slave (
        output en,
        input  sx, sy, de, hsync, vsync, line, frame, frame_cnt
    );
endinterface

// File: rtl/display_timing_gen.sv
// Parameterised raster timing generator in the pixel clock domain.
// Flags are derived from the next coordinate so they register alongside it.
module display_timing_gen #(
    parameter int CORDW  = 10,
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0,
    parameter int FRAMEW = 16
) (
    input  logic                clk_pix,
    input  logic                rst_pix,
    display_timing_gen_if.master tim
);
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] C_ZERO = {CORDW{1'b0}};
    localparam logic [CORDW-1:0] C_ONE  = {{(CORDW-1){1'b0}}, 1'b1};
    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACTV = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACTV = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);
    localparam logic [FRAMEW-1:0] F_ONE = {{(FRAMEW-1){1'b0}}, 1'b1};
    localparam logic H_ACT = (H_POL != 0) ? 1'b1 : 1'b0;
    localparam logic V_ACT = (V_POL != 0) ? 1'b1 : 1'b0;

    if ((64'(H_TOTAL) > (64'd1 << CORDW)) || (64'(V_TOTAL) > (64'd1 << CORDW))) begin : g_cordw_too_small
        $fatal(1, "display_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CORDW-1:0]  sx_r, sy_r;
    logic              de_r, hsync_r, vsync_r, line_r, frame_r;
    logic [FRAMEW-1:0] frame_cnt_r;

    logic [CORDW-1:0]  sx_nxt_s, sy_nxt_s;
    logic              de_nxt_s, hsync_nxt_s, vsync_nxt_s, line_nxt_s, frame_nxt_s;
    logic [FRAMEW-1:0] frame_cnt_nxt_s;

    // Next raster position and the flags describing that position
    always_comb begin
        sx_nxt_s = sx_r;
        sy_nxt_s = sy_r;
        if (sx_r == H_LAST) begin
            sx_nxt_s = C_ZERO;
            if (sy_r == V_LAST) begin
                sy_nxt_s = C_ZERO;
            end else begin
                sy_nxt_s = sy_r + C_ONE;
            end
        end else begin
            sx_nxt_s = sx_r + C_ONE;
        end
        line_nxt_s  = (sx_nxt_s == C_ZERO);
        frame_nxt_s = line_nxt_s && (sy_nxt_s == C_ZERO);
        de_nxt_s    = (sx_nxt_s < H_ACTV) && (sy_nxt_s < V_ACTV);
        hsync_nxt_s = ((sx_nxt_s >= HS_BEG) && (sx_nxt_s <= HS_END)) ? H_ACT : ~H_ACT;
        vsync_nxt_s = ((sy_nxt_s >= VS_BEG) && (sy_nxt_s <= VS_END)) ? V_ACT : ~V_ACT;
        if (frame_nxt_s) begin
            frame_cnt_nxt_s = frame_cnt_r + F_ONE;
        end else begin
            frame_cnt_nxt_s = frame_cnt_r;
        end
    end

    // Output registers; reset parks on the last position so the first advance opens frame 1
    always_ff @(posedge clk_pix or negedge rst_pix) begin
        if (!rst_pix) begin
            sx_r        <= H_LAST;
            sy_r        <= V_LAST;
            de_r        <= 1'b0;
            hsync_r     <= ~H_ACT;
            vsync_r     <= ~V_ACT;
            line_r      <= 1'b0;
            frame_r     <= 1'b0;
            frame_cnt_r <= {FRAMEW{1'b0}};
        end else if (tim.en) begin
            sx_r        <= sx_nxt_s;
            sy_r        <= sy_nxt_s;
            de_r        <= de_nxt_s;
            hsync_r     <= hsync_nxt_s;
            vsync_r     <= vsync_nxt_s;
            line_r      <= line_nxt_s;
            frame_r     <= frame_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
        end
    end

    assign tim.sx        = sx_r;
    assign tim.sy        = sy_r;
    assign tim.de        = de_r;
    assign tim.hsync     = hsync_r;
    assign tim.vsync     = vsync_r;
    assign tim.line      = line_r;
    assign tim.frame     = frame_r;
    assign tim.frame_cnt = frame_cnt_r;
endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: default 640x480 instance plus two small rasters
// (25x11 total), one with FRAMEW=2 and active-high syncs.
module tb_display_timing_gen;
    typedef struct packed {
        logic [9:0]  sx;
        logic [9:0]  sy;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ln;
        logic        fr;
        logic [15:0] fc;
    } obs_t;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b0;
    logic en      = 1'b0;
    int   n_chk   = 0;
    int   n_err   = 0;
    int   adv     = 0;
    obs_t q_d[$], q_a[$], q_b[$];

    always #5 clk_pix = ~clk_pix;

    display_timing_gen_if #(.CORDW(10), .FRAMEW(16)) if_d ();
    display_timing_gen_if #(.CORDW(5),  .FRAMEW(16)) if_a ();
    display_timing_gen_if #(.CORDW(5),  .FRAMEW(2))  if_b ();
    assign if_d.en = en;
    assign if_a.en = en;
    assign if_b.en = en;

    display_timing_gen u_d (.clk_pix(clk_pix), .rst_pix(rst_pix), .tim(if_d));

    display_timing_gen #(
        .CORDW(5), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(0), .V_POL(0), .FRAMEW(16)
    ) u_a (.clk_pix(clk_pix), .rst_pix(rst_pix), .tim(if_a));

    display_timing_gen #(
        .CORDW(5), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1), .V_POL(1), .FRAMEW(2)
    ) u_b (.clk_pix(clk_pix), .rst_pix(rst_pix), .tim(if_b));

    // Expected outputs after 'a' enabled advances since reset, from the absolute raster index
    function automatic obs_t model(input int a, input int hr, input int hfp, input int hsw, input int hbp,
                                   input int vr, input int vfp, input int vsw, input int vbp,
                                   input logic hpol, input logic vpol, input int fw);
        int ht = hr + hfp + hsw + hbp;
        int vt = vr + vfp + vsw + vbp;
        int p, x, y;
        obs_t o;
        if (a == 0) begin
            o.sx = 10'(ht - 1);  o.sy = 10'(vt - 1);
            o.de = 1'b0;         o.hs = ~hpol;  o.vs = ~vpol;
            o.ln = 1'b0;         o.fr = 1'b0;   o.fc = 16'd0;
        end else begin
            p = (a - 1) % (ht * vt);
            x = p % ht;
            y = p / ht;
            o.sx = 10'(x);
            o.sy = 10'(y);
            o.de = (x < hr) && (y < vr);
            o.hs = (x >= hr + hfp && x < hr + hfp + hsw) ? hpol : ~hpol;
            o.vs = (y >= vr + vfp && y < vr + vfp + vsw) ? vpol : ~vpol;
            o.ln = (x == 0);
            o.fr = (p == 0);
            o.fc = 16'((((a - 1) / (ht * vt)) + 1) % (1 << fw));
        end
        return o;
    endfunction

    function automatic obs_t mk(input logic [9:0] sx, input logic [9:0] sy, input logic de, input logic hs,
                                input logic vs, input logic ln, input logic fr, input logic [15:0] fc);
        obs_t o;
        o.sx = sx; o.sy = sy; o.de = de; o.hs = hs; o.vs = vs; o.ln = ln; o.fr = fr; o.fc = fc;
        return o;
    endfunction

    task automatic push_all(input int a);
        q_d.push_back(model(a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 16));
        q_a.push_back(model(a, 16, 2, 3, 4, 6, 1, 2, 2, 1'b0, 1'b0, 16));
        q_b.push_back(model(a, 16, 2, 3, 4, 6, 1, 2, 2, 1'b1, 1'b1, 2));
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_obs(input string nm, input obs_t got, input obs_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL obs_%s @%0t: got sx=%0d sy=%0d de/hs/vs/ln/fr=%b%b%b%b%b fc=%0d expected sx=%0d sy=%0d de/hs/vs/ln/fr=%b%b%b%b%b fc=%0d",
                     nm, $time, got.sx, got.sy, got.de, got.hs, got.vs, got.ln, got.fr, got.fc,
                     exp.sx, exp.sy, exp.de, exp.hs, exp.vs, exp.ln, exp.fr, exp.fc);
        end
    endtask

    // Stimulus side of the scoreboard: every clock edge yields one expected output set
    initial begin
        forever begin
            @(posedge clk_pix);
            if (!rst_pix) adv = 0;
            else if (en) adv = adv + 1;
            push_all(adv);
        end
    end

    // Asynchronous reset discards pending expectations and expects reset values at once
    initial begin
        forever begin
            @(negedge rst_pix);
            adv = 0;
            q_d.delete(); q_a.delete(); q_b.delete();
            push_all(0);
        end
    end

    // Monitor: compare what the DUTs present mid-cycle against the queued expectations
    initial begin
        forever begin
            @(negedge clk_pix);
            if (q_d.size() > 0)
                chk_obs("d", mk(if_d.sx, if_d.sy, if_d.de, if_d.hsync, if_d.vsync, if_d.line, if_d.frame,
                                if_d.frame_cnt), q_d.pop_front());
            if (q_a.size() > 0)
                chk_obs("a", mk(10'(if_a.sx), 10'(if_a.sy), if_a.de, if_a.hsync, if_a.vsync, if_a.line,
                                if_a.frame, if_a.frame_cnt), q_a.pop_front());
            if (q_b.size() > 0)
                chk_obs("b", mk(10'(if_b.sx), 10'(if_b.sy), if_b.de, if_b.hsync, if_b.vsync, if_b.line,
                                if_b.frame, 16'(if_b.frame_cnt)), q_b.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk_pix);
        #1;
    endtask

    function automatic int cur_x(input int w);
        return (w == 1) ? int'(if_a.sx) : (w == 2) ? int'(if_b.sx) : int'(if_d.sx);
    endfunction

    function automatic int cur_y(input int w);
        return (w == 1) ? int'(if_a.sy) : (w == 2) ? int'(if_b.sy) : int'(if_d.sy);
    endfunction

    task automatic wait_pos(input int w, input int x, input int y, input int maxc, input string nm,
                            output int steps);
        steps = 0;
        while (!(cur_x(w) == x && cur_y(w) == y) && steps < maxc) begin
            cyc();
            steps++;
        end
        if (steps >= maxc) chk({nm, "_timeout"}, steps, -1);
    endtask

    initial begin
        int de_cnt, hs_cnt, hs_first, hs_last, ln_cnt, vs_cnt, de_late, steps, total;
        int fexp[5] = '{1, 2, 3, 0, 1};
        logic [15:0] fc0;

        // Reset held for five cycles
        repeat (5) cyc();
        chk("rst_sx", if_d.sx, 799);
        chk("rst_sy", if_d.sy, 524);
        chk("rst_de", if_d.de, 0);
        chk("rst_hsync", if_d.hsync, 1);
        chk("rst_vsync", if_d.vsync, 1);
        chk("rst_line_frame", {if_d.line, if_d.frame}, 0);
        chk("rst_fcnt", if_d.frame_cnt, 0);
        rst_pix = 1'b1;
        en = 1'b1;
        cyc();
        chk("first_sx_sy", {if_d.sx, if_d.sy}, 0);
        chk("first_de_line_frame", {if_d.de, if_d.line, if_d.frame}, 3'b111);
        chk("first_fcnt", if_d.frame_cnt, 1);

        // One full default line
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ln_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (if_d.de) de_cnt++;
            if (!if_d.hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(if_d.sx);
                hs_last = int'(if_d.sx);
            end
            if (if_d.line) ln_cnt++;
            cyc();
        end
        chk("line_de_cnt", de_cnt, 640);
        chk("line_hs_cnt", hs_cnt, 96);
        chk("line_hs_first", hs_first, 656);
        chk("line_hs_last", hs_last, 751);
        chk("line_strobes", ln_cnt, 1);
        chk("line_wrap_sx", if_d.sx, 0);
        chk("line_wrap_sy", if_d.sy, 1);

        // One full small frame
        wait_pos(1, 0, 0, 400, "a_frame", steps);
        fc0 = if_a.frame_cnt;
        vs_cnt = 0; de_late = 0; de_cnt = 0;
        for (int i = 0; i < 275; i++) begin
            if (!if_a.vsync) vs_cnt++;
            if (if_a.de && if_a.sy >= 5'd6) de_late++;
            if (if_a.de) de_cnt++;
            cyc();
        end
        chk("frame_vs_cnt", vs_cnt, 50);
        chk("frame_de_blank", de_late, 0);
        chk("frame_de_cnt", de_cnt, 96);
        chk("frame_wrap_pos", {if_a.sx, if_a.sy, if_a.frame}, 11'd1);
        chk("frame_fcnt_step", if_a.frame_cnt, 16'(fc0 + 16'd1));

        // Stall on the frame strobe, then mid-frame; the period grows by the mid-frame stall
        en = 1'b0;
        repeat (3) cyc();
        chk("stall_strobes_held", {if_a.line, if_a.frame, if_a.sx}, 7'b1100000);
        en = 1'b1;
        wait_pos(1, 10, 3, 400, "a_stall_pos", steps);
        chk("stall_reach", steps, 85);
        total = steps;
        en = 1'b0;
        repeat (10) cyc();
        chk("stall_hold_pos", {if_a.sx, if_a.sy}, {5'd10, 5'd3});
        chk("stall_hold_flags", {if_a.de, if_a.line, if_a.frame}, 3'b100);
        en = 1'b1;
        cyc();
        chk("stall_resume_sx", if_a.sx, 11);
        total = total + 11;
        wait_pos(1, 0, 0, 400, "a_stall_frame", steps);
        chk("stall_period", total + steps, 285);

        // Asynchronous reset in the middle of a cycle
        wait_pos(1, 20, 8, 400, "a_rst_pos", steps);
        @(posedge clk_pix);
        #2 rst_pix = 1'b0;
        #1;
        chk("async_rst_a_pos", {if_a.sx, if_a.sy}, {5'd24, 5'd10});
        chk("async_rst_a_flags", {if_a.de, if_a.hsync, if_a.vsync, if_a.line, if_a.frame}, 5'b01100);
        chk("async_rst_a_fcnt", if_a.frame_cnt, 0);
        chk("async_rst_d_pos", {if_d.sx, if_d.sy}, {10'd799, 10'd524});
        @(posedge clk_pix);
        #1 rst_pix = 1'b1;
        cyc();
        chk("post_rst_pos", {if_a.sx, if_a.sy, if_a.frame}, 11'd1);
        chk("post_rst_fcnt", if_a.frame_cnt, 1);

        // Narrow frame counter wrap and active-high syncs
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fcnt_wrap_%0d", k), if_b.frame_cnt, fexp[k]);
            if (k == 0) begin
                hs_cnt = 0; vs_cnt = 0; hs_first = -1;
                for (int i = 0; i < 275; i++) begin
                    if (if_b.hsync) begin
                        hs_cnt++;
                        if (hs_first < 0) hs_first = int'(if_b.sx);
                    end
                    if (if_b.vsync) vs_cnt++;
                    cyc();
                end
                chk("pol_hs_cnt", hs_cnt, 33);
                chk("pol_hs_first", hs_first, 18);
                chk("pol_vs_cnt", vs_cnt, 50);
            end else if (k < 4) begin
                cyc();
                wait_pos(2, 0, 0, 400, "b_frame", steps);
            end
        end

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
